// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage controller: owns the PC, issues one instruction-memory request at a
// time, buffers the returned word for decode and handles branch redirects.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_imm,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] target;
  logic [31:0] pc_seq;
  logic        kill;

  assign target    = br_pc + br_imm;
  assign pc_seq    = pc + 32'd4;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A redirect never changes the REQ/HOLD exits except HOLD, where it forces REQ;
  // in RESP it only short-circuits the kill round-trip when rvalid coincides.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: state_next = REQ;
      REQ:  if (imem_gnt) state_next = RESP;
      RESP: begin
        if (imem_rvalid) state_next = (br_taken || kill) ? REQ : HOLD;
      end
      HOLD: if (br_taken || if_ready) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state == REQ);
    if_valid = (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      kill     <= 1'b0;
      if_instr <= '0;
      if_pc    <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      misalign <= br_taken && (target[1:0] != 2'b00);
      if (br_taken) begin
        pc <= {target[31:2], 2'b00};
        // Any request already granted must have its response thrown away.
        if (state == REQ && imem_gnt) kill <= 1'b1;
        else if (state == RESP)       kill <= !imem_rvalid;
      end else begin
        unique case (state)
          RESP: begin
            if (imem_rvalid) begin
              if (kill) begin
                kill <= 1'b0;
              end else begin
                if_instr <= imem_rdata;
                if_pc    <= pc;
              end
            end
          end
          HOLD: if (if_ready) pc <= pc_seq;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Fetch-stage controller for the RV32I core. Owns the program-counter register and sequences instruction fetch: issues one request at a time to instruction memory, buffers the returned word for decode, and advances the PC. The PC advances by PC+4 on each accepted instruction, or by the branch target PC+ImmExt when a redirect is signalled. Sits between the next-PC datapath and the instruction-memory port, feeding the decode stage through a valid/ready handshake.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset; must be word-aligned.
- `clk` in, 1: system clock; all state updates on the rising edge.
- `rst_n` in, 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `imem_req` out, 1: fetch request valid.
- `imem_addr` out, 32: fetch address; equals the current PC.
- `imem_gnt` in, 1: memory accepts the request (`imem_req`&&`imem_gnt` = address handshake).
- `imem_rvalid` in, 1: response valid, one cycle per accepted request.
- `imem_rdata` in, 32: instruction word, qualified by `imem_rvalid`.
- `if_valid` out, 1: instruction presented to decode.
- `if_instr` out, 32: buffered instruction word.
- `if_pc` out, 32: PC of `if_instr`.
- `if_ready` in, 1: decode accepts (`if_valid`&&`if_ready` = consume).
- `br_taken` in, 1: redirect request (PCSrc), single-cycle pulse.
- `br_pc` in, 32: PC of the branching instruction.
- `br_imm` in, 32: sign-extended immediate.
- `misalign` out, 1: one-cycle pulse when a redirect target has bits [1:0] ≠ 0.

## Operation
- **State machine.** States are IDLE, REQ, RESP and HOLD. Outputs are Moore: `imem_req` = (state==REQ) and `if_valid` = (state==HOLD).
- **Target.** target = (`br_pc` + `br_imm`) mod 2^32.
  - Bits [1:0] are forced to 0 before loading into the PC.
  - `misalign` pulses the cycle after `br_taken` when the raw target bits [1:0] ≠ 0.
- **Sequential next PC:** PC + 4, wrapping `32'hFFFF_FFFC` → `32'h0000_0000`.
- **IDLE:** go to REQ on the next edge, unconditionally.
- **REQ:**
  - On `imem_gnt`, go to RESP.
  - `imem_addr` is held stable while waiting for grant, unless a redirect occurs.
- **RESP:** on `imem_rvalid`, capture `imem_rdata` into `if_instr`, capture PC into `if_pc`, and go to HOLD.
- **HOLD:** on `if_ready`, set PC ← PC+4 and go to REQ.
- **Redirect (`br_taken`=1) has priority over any handshake completing in the same cycle:**
  - IDLE: PC ← target; go to REQ.
  - REQ, no grant: PC ← target; stay in REQ. The address changes on the next cycle, which is legal while ungranted.
  - REQ with `imem_gnt` in the same cycle: the old request is in flight. Set `kill` and PC ← target; go to RESP.
  - RESP: set `kill` and PC ← target. If `imem_rvalid` arrives in the same cycle, discard the word and go to REQ.
  - HOLD: drop the buffered instruction, PC ← target, go to REQ, even if `if_ready`=1 in the same cycle.
- **Kill.** In RESP with `kill` set, `imem_rvalid` discards the data, clears `kill`, and goes to REQ without touching `if_instr`/`if_pc`.
- **Stray responses.** `imem_rvalid` outside RESP is ignored.
- **Reset.**
  - Any state → IDLE.
  - PC, `imem_addr` and `if_pc` = `RESET_PC`.
  - `if_instr` = 0; `imem_req`, `if_valid`, `misalign` and `kill` = 0.
  - A response outstanding when reset was asserted is ignored.

## Timing
- Reset released at edge k: IDLE at k, REQ (with `imem_req`=1) after edge k+1.
- Zero-wait memory (`imem_gnt` same cycle, `imem_rvalid` the cycle after grant):
  - Address grant at edge n, `imem_rvalid` at edge n+1, `if_valid` high after edge n+1.
  - With `if_ready` tied high, a new request follows one cycle later: 3 cycles per instruction.
- `if_instr` and `if_pc` are stable while `if_valid`=1 and `if_ready`=0.
- Redirect latency: `br_taken` sampled at edge t; `imem_addr` = target from t+1 (REQ/IDLE/HOLD cases).
- `misalign` is asserted for exactly the cycle after edge t.
- At most one request is outstanding; a new request is never issued until the prior response is received or killed.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `RESET_PC`=`32'h0000_0100`. Then `imem_addr`=0x100, `imem_req`=0, `if_valid`=0. `imem_req` rises one cycle after release.
- **Sequential fetch:** zero-wait memory, `if_ready`=1, rdata = address ^ `32'hA5A5_0000`. `if_pc` sequence is 0x100, 0x104, 0x108 with matching `if_instr`, spaced 3 cycles apart.
- **Decode backpressure:** with `if_ready`=0 for 5 cycles in HOLD, `if_valid`, `if_instr` and `if_pc` stay stable and `imem_req`=0. After `if_ready` rises, the next address is +4.
- **Redirect in flight:**
  - Pulse `br_taken` with `br_pc`=0x104 and `br_imm`=`32'hFFFF_FFF0` in the same cycle as `imem_gnt`.
  - The response for the old address is discarded (no `if_valid`).
  - The next request is 0xF4, and `if_pc`=0xF4.
- **Misaligned target and wrap:**
  - `br_pc`=`32'hFFFF_FFF8`, `br_imm`=6 → `misalign` pulses once and `imem_addr`=`32'hFFFF_FFFC`.
  - The next sequential fetch address is 0x0.
- **Redirect with handshake in HOLD:** `br_taken` and `if_ready` asserted in the same cycle. The redirect wins: there is no +4 fetch, and `imem_addr`=target.
- **Reset mid-fetch:** assert `rst_n`=0 while in RESP, then release. A late `imem_rvalid` after release is ignored, and the first fetch is `RESET_PC`.
